// File: rtl/disp_src_arbiter.sv
// Four-source arbiter driving an 8-digit multiplexed hex display.
// Optional macro DISP_AUTO_ROTATE_EN compiles in dwell-timer auto-rotation.
module disp_src_arbiter #(
    parameter int SCAN_DIV     = 12500,
    parameter int DWELL_CYCLES = 100_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   src_valid,
    input  logic [127:0] src_data,
    input  logic         next_btn,
    input  logic         hold,
    output logic [7:0]   anode,
    output logic [6:0]   cathode,
    output logic         dp,
    output logic [1:0]   cur_src
);

    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [3:0][31:0] data_arr;
    assign data_arr = src_data;

    logic          btn_q;
    logic [1:0]    cur_q, cur_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [2:0]    digit_q, digit_d;
    logic [31:0]   snap_q, snap_d;
    logic [7:0]    anode_q, anode_d;
    logic [6:0]    cath_q, cath_d;
    logic          dp_q, dp_d;

    logic btn_evt, dwell_evt, adv, found, slot_end, frame_end;
    logic [1:0] nxt_src, cand;

    assign btn_evt   = next_btn & ~btn_q;
    assign adv       = btn_evt | dwell_evt;
    assign slot_end  = (scan_q == SCAN_LAST);
    assign frame_end = slot_end && (digit_q == 3'd7);

`ifdef DISP_AUTO_ROTATE_EN
    localparam int DW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    logic [DW-1:0] dwell_q, dwell_d;

    // Expiry is ignored while frozen so a held counter cannot fire repeatedly.
    assign dwell_evt = ~hold && (dwell_q == DWELL_LAST);

    always_comb begin
        dwell_d = dwell_q;
        if (adv)        dwell_d = '0;
        else if (!hold) dwell_d = dwell_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) dwell_q <= '0;
        else       dwell_q <= dwell_d;
    end
`else
    assign dwell_evt = 1'b0;
`endif

    // Walk from farthest to nearest so the nearest valid candidate wins.
    always_comb begin
        nxt_src = cur_q;
        found   = 1'b0;
        cand    = cur_q;
        for (int j = 3; j >= 1; j--) begin
            cand = cur_q + 2'(j);
            if (src_valid[cand]) begin
                nxt_src = cand;
                found   = 1'b1;
            end
        end
    end

    function automatic logic [6:0] hex_font(input logic [3:0] n);
        case (n)
            4'h0: hex_font = 7'b1000000;
            4'h1: hex_font = 7'b1111001;
            4'h2: hex_font = 7'b0100100;
            4'h3: hex_font = 7'b0110000;
            4'h4: hex_font = 7'b0011001;
            4'h5: hex_font = 7'b0010010;
            4'h6: hex_font = 7'b0000010;
            4'h7: hex_font = 7'b1111000;
            4'h8: hex_font = 7'b0000000;
            4'h9: hex_font = 7'b0010000;
            4'hA: hex_font = 7'b0001000;
            4'hB: hex_font = 7'b0000011;
            4'hC: hex_font = 7'b1000110;
            4'hD: hex_font = 7'b0100001;
            4'hE: hex_font = 7'b0000110;
            default: hex_font = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        cur_d   = (adv && found) ? nxt_src : cur_q;
        scan_d  = slot_end ? '0 : scan_q + 1'b1;
        digit_d = slot_end ? digit_q + 3'd1 : digit_q;
        snap_d  = snap_q;
        // A source switch reloads immediately; otherwise only on frame wrap.
        if (adv && found)   snap_d = data_arr[nxt_src];
        else if (frame_end) snap_d = data_arr[cur_q];
        anode_d = src_valid[cur_q] ? ~(8'd1 << digit_q) : 8'hFF;
        cath_d  = hex_font(snap_q[{digit_q, 2'b00} +: 4]);
        dp_d    = ~(hold && (digit_q == 3'd7));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q   <= 1'b0;
            cur_q   <= 2'd0;
            scan_q  <= '0;
            digit_q <= 3'd0;
            snap_q  <= 32'd0;
            anode_q <= 8'hFF;
            cath_q  <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            btn_q   <= next_btn;
            cur_q   <= cur_d;
            scan_q  <= scan_d;
            digit_q <= digit_d;
            snap_q  <= snap_d;
            anode_q <= anode_d;
            cath_q  <= cath_d;
            dp_q    <= dp_d;
        end
    end

    assign anode   = anode_q;
    assign cathode = cath_q;
    assign dp      = dp_q;
    assign cur_src = cur_q;

endmodule
